// File: rtl/median_window_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : median_window_ctrl
//  Purpose  : Sequencer for the median filter datapath. On a start request
//             it walks a packed image (4 pixels per 32-bit word) held in a
//             synchronous-read RAM. For every output position (r, c) it
//             fetches the three vertically adjacent words (line r-1, r, r+1)
//             and presents them as word0/word1/word2 with a valid/ready
//             handshake. When the last window is accepted it pulses
//             end_of_operation.
//
//  Ports    :
//    clk                  in   1       rising-edge clock
//    rst_n                in   1       asynchronous active-low reset
//    start                in   1       single-cycle frame request (IDLE only)
//    mem_rd_en            out  1       image RAM read strobe (registered)
//    mem_rd_addr          out  ADDR_W  image RAM word address (registered)
//    mem_rd_data          in   32      RAM data, valid 1 cycle after strobe
//    word0/word1/word2    out  32      window words: above, centre, below
//    win_valid            out  1       window words valid
//    win_ready            in   1       datapath accepts the window
//    waddr                out  10      column word index of the window
//    window_line_counter  out  2       output line index modulo 3
//    busy                 out  1       frame in progress
//    end_of_operation     out  1       1-cycle pulse after the last window
//
//  Revision : 1.0 - initial release
// ============================================================================
module median_window_ctrl #(
   parameter int IMG_W  = 228,
   parameter int IMG_H  = 228,
   parameter int ADDR_W = 14
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [31:0]       mem_rd_data,
   output logic [31:0]       word0,
   output logic [31:0]       word1,
   output logic [31:0]       word2,
   output logic              win_valid,
   input  logic              win_ready,
   output logic [9:0]        waddr,
   output logic [1:0]        window_line_counter,
   output logic              busy,
   output logic              end_of_operation
);

   // Words per image line and the derived limits. These are elaboration-time
   // constants; the address path itself only ever adds.
   localparam int                c_wpl_int   = IMG_W / 4;
   localparam logic [ADDR_W-1:0] c_wpl       = ADDR_W'(c_wpl_int);
   localparam logic [9:0]        c_last_col  = 10'(c_wpl_int - 1);
   // Line base of the last output line (r = IMG_H-2): (r-1)*WPL.
   localparam logic [ADDR_W-1:0] c_last_base = ADDR_W'((IMG_H - 3) * c_wpl_int);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD0  = 3'd1,
      S_RD1  = 3'd2,
      S_RD2  = 3'd3,
      S_CAP  = 3'd4,
      S_PRES = 3'd5,
      S_DONE = 3'd6
   } state_t;

   state_t            r_state;
   state_t            w_next_state;

   // Window position. r_line_base holds (r-1)*WPL, i.e. the word address of
   // the line above the current centre line.
   logic [9:0]        r_col;
   logic [ADDR_W-1:0] r_line_base;
   logic [1:0]        r_wlc;

   logic [9:0]        w_col_nxt;
   logic [ADDR_W-1:0] w_base_nxt;
   logic [1:0]        w_wlc_nxt;

   logic              w_last_col;
   logic              w_last_win;

   logic              w_rd_en_nxt;
   logic [ADDR_W-1:0] w_rd_addr_nxt;

   assign w_last_col = (r_col == c_last_col);
   assign w_last_win = w_last_col && (r_line_base == c_last_base);

   assign waddr               = r_col;
   assign window_line_counter = r_wlc;

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state, position update and state-decoded outputs
   // -------------------------------------------------------------------------
   always_comb begin
      w_next_state     = r_state;
      w_col_nxt        = r_col;
      w_base_nxt       = r_line_base;
      w_wlc_nxt        = r_wlc;
      win_valid        = 1'b0;
      busy             = 1'b0;
      end_of_operation = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (start) begin
               // Every frame starts at r=1, c=0 regardless of history.
               w_next_state = S_RD0;
               w_col_nxt    = '0;
               w_base_nxt   = '0;
               w_wlc_nxt    = '0;
            end
         end

         S_RD0: begin
            busy         = 1'b1;
            w_next_state = S_RD1;
         end

         S_RD1: begin
            busy         = 1'b1;
            w_next_state = S_RD2;
         end

         S_RD2: begin
            busy         = 1'b1;
            w_next_state = S_CAP;
         end

         S_CAP: begin
            busy         = 1'b1;
            w_next_state = S_PRES;
         end

         S_PRES: begin
            busy      = 1'b1;
            win_valid = 1'b1;
            if (win_ready) begin
               if (w_last_win) begin
                  w_next_state = S_DONE;
               end else begin
                  w_next_state = S_RD0;
                  if (w_last_col) begin
                     w_col_nxt  = '0;
                     w_base_nxt = r_line_base + c_wpl;
                     w_wlc_nxt  = (r_wlc == 2'd2) ? 2'd0 : r_wlc + 2'd1;
                  end else begin
                     w_col_nxt  = r_col + 10'd1;
                  end
               end
            end
         end

         S_DONE: begin
            // busy is already low here; start is deliberately not examined.
            end_of_operation = 1'b1;
            w_next_state     = S_IDLE;
         end

         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Read strobe / address. Both are registered, so they are computed from
   // the state being entered. On entry to RD0 the address is formed from the
   // position that is being loaded in the same edge; RD1 and RD2 step down
   // one line each by adding WPL to the previous read address.
   // -------------------------------------------------------------------------
   always_comb begin
      w_rd_en_nxt   = 1'b0;
      w_rd_addr_nxt = mem_rd_addr;

      case (w_next_state)
         S_RD0: begin
            w_rd_en_nxt   = 1'b1;
            w_rd_addr_nxt = w_base_nxt + ADDR_W'(w_col_nxt);
         end
         S_RD1, S_RD2: begin
            w_rd_en_nxt   = 1'b1;
            w_rd_addr_nxt = mem_rd_addr + c_wpl;
         end
         default: begin
            w_rd_en_nxt   = 1'b0;
            w_rd_addr_nxt = mem_rd_addr;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Position counters, read port and window word capture
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col       <= '0;
         r_line_base <= '0;
         r_wlc       <= '0;
         mem_rd_en   <= 1'b0;
         mem_rd_addr <= '0;
         word0       <= '0;
         word1       <= '0;
         word2       <= '0;
      end else begin
         r_col       <= w_col_nxt;
         r_line_base <= w_base_nxt;
         r_wlc       <= w_wlc_nxt;
         mem_rd_en   <= w_rd_en_nxt;
         mem_rd_addr <= w_rd_addr_nxt;

         // RAM data for the read issued in state X arrives during the
         // following state, so each word is captured one state late.
         if (r_state == S_RD1) begin
            word0 <= mem_rd_data;
         end
         if (r_state == S_RD2) begin
            word1 <= mem_rd_data;
         end
         if (r_state == S_CAP) begin
            word2 <= mem_rd_data;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_median_window_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_median_window_ctrl
//  Purpose  : Self-checking bench for median_window_ctrl. One instance uses
//             the default 228x228 geometry, a second uses an 8x6 image so
//             that line wrap and frame completion are reachable quickly.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_median_window_ctrl;

   localparam int SW   = 8;
   localparam int SH   = 6;
   localparam int SA   = 4;
   localparam int SWPL = SW / 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- default-geometry instance ----------------
   logic        rstb_n, start_b, rd_en_b, valid_b, ready_b, busy_b, eoo_b;
   logic [13:0] addr_b;
   logic [31:0] rdata_b = '0;
   logic [31:0] w0_b, w1_b, w2_b;
   logic [9:0]  waddr_b;
   logic [1:0]  wlc_b;

   median_window_ctrl u_big (
      .clk                 (clk),
      .rst_n               (rstb_n),
      .start               (start_b),
      .mem_rd_en           (rd_en_b),
      .mem_rd_addr         (addr_b),
      .mem_rd_data         (rdata_b),
      .word0               (w0_b),
      .word1               (w1_b),
      .word2               (w2_b),
      .win_valid           (valid_b),
      .win_ready           (ready_b),
      .waddr               (waddr_b),
      .window_line_counter (wlc_b),
      .busy                (busy_b),
      .end_of_operation    (eoo_b)
   );

   // ---------------- small-geometry instance ----------------
   logic          rsts_n, start_s, rd_en_s, valid_s, ready_s, busy_s, eoo_s;
   logic [SA-1:0] addr_s;
   logic [31:0]   rdata_s = '0;
   logic [31:0]   w0_s, w1_s, w2_s;
   logic [9:0]    waddr_s;
   logic [1:0]    wlc_s;

   median_window_ctrl #(.IMG_W(SW), .IMG_H(SH), .ADDR_W(SA)) u_small (
      .clk                 (clk),
      .rst_n               (rsts_n),
      .start               (start_s),
      .mem_rd_en           (rd_en_s),
      .mem_rd_addr         (addr_s),
      .mem_rd_data         (rdata_s),
      .word0               (w0_s),
      .word1               (w1_s),
      .word2               (w2_s),
      .win_valid           (valid_s),
      .win_ready           (ready_s),
      .waddr               (waddr_s),
      .window_line_counter (wlc_s),
      .busy                (busy_s),
      .end_of_operation    (eoo_s)
   );

   // ---------------- synchronous-read RAM models ----------------
   logic [31:0] mem_b [0:16383];
   logic [31:0] mem_s [0:15];

   always @(posedge clk) if (rd_en_b) rdata_b <= mem_b[addr_b];
   always @(posedge clk) if (rd_en_s) rdata_s <= mem_s[addr_s];

   // ---------------- scoring ----------------
   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic zero_b(input string tag);
      check({tag, "_rd_en"}, 64'(rd_en_b), 64'(0));
      check({tag, "_addr"},  64'(addr_b),  64'(0));
      check({tag, "_w0"},    64'(w0_b),    64'(0));
      check({tag, "_w1"},    64'(w1_b),    64'(0));
      check({tag, "_w2"},    64'(w2_b),    64'(0));
      check({tag, "_valid"}, 64'(valid_b), 64'(0));
      check({tag, "_waddr"}, 64'(waddr_b), 64'(0));
      check({tag, "_wlc"},   64'(wlc_b),   64'(0));
      check({tag, "_busy"},  64'(busy_b),  64'(0));
      check({tag, "_eoo"},   64'(eoo_b),   64'(0));
   endtask

   task automatic zero_s(input string tag);
      check({tag, "_rd_en"}, 64'(rd_en_s), 64'(0));
      check({tag, "_addr"},  64'(addr_s),  64'(0));
      check({tag, "_w0"},    64'(w0_s),    64'(0));
      check({tag, "_w1"},    64'(w1_s),    64'(0));
      check({tag, "_w2"},    64'(w2_s),    64'(0));
      check({tag, "_valid"}, 64'(valid_s), 64'(0));
      check({tag, "_waddr"}, 64'(waddr_s), 64'(0));
      check({tag, "_wlc"},   64'(wlc_s),   64'(0));
      check({tag, "_busy"},  64'(busy_s),  64'(0));
      check({tag, "_eoo"},   64'(eoo_s),   64'(0));
   endtask

   // ---------------- reference model state ----------------
   int          exp_rd [$];
   logic [31:0] exp_w0 [$];
   logic [31:0] exp_w1 [$];
   logic [31:0] exp_w2 [$];
   int          exp_c  [$];
   int          exp_l  [$];

   int          seen, cnt, windows, rd_idx;
   logic        injected, stalled, done;
   logic [31:0] pw0, pw1, pw2;
   logic [9:0]  pwa;
   logic [1:0]  pwl;

   initial begin
      for (int i = 0; i < 16384; i++) mem_b[i] = $urandom;
      for (int i = 0; i < 16; i++)    mem_s[i] = $urandom;
      mem_b[0]   = 32'h11111111;
      mem_b[57]  = 32'h22222222;
      mem_b[114] = 32'h33333333;

      rstb_n = 1'b0; rsts_n = 1'b0;
      start_b = 1'b0; start_s = 1'b0;
      ready_b = 1'b0; ready_s = 1'b0;

      // ---- reset, then idle ----
      repeat (3) tick();
      zero_b("reset_b");
      zero_s("reset_s");
      rstb_n = 1'b1; rsts_n = 1'b1;
      seen = 0;
      repeat (10) begin
         tick();
         if (rd_en_b || rd_en_s || busy_b || busy_s) seen++;
      end
      check("idle_no_activity", 64'(seen), 64'(0));

      // ---- first window, default geometry; held in PRES for backpressure ----
      start_b = 1'b1;
      tick();                       // cycle T+1
      start_b = 1'b0;
      check("t1_busy",  64'(busy_b),  64'(1));
      check("t1_rd_en", 64'(rd_en_b), 64'(1));
      check("t1_addr",  64'(addr_b),  64'(0));
      tick();
      check("t2_rd_en", 64'(rd_en_b), 64'(1));
      check("t2_addr",  64'(addr_b),  64'(57));
      tick();
      check("t3_rd_en", 64'(rd_en_b), 64'(1));
      check("t3_addr",  64'(addr_b),  64'(114));
      tick();
      check("t4_rd_en", 64'(rd_en_b), 64'(0));
      check("t4_valid", 64'(valid_b), 64'(0));
      tick();                       // cycle T+5
      check("t5_valid", 64'(valid_b), 64'(1));
      check("t5_w0",    64'(w0_b),    64'(32'h11111111));
      check("t5_w1",    64'(w1_b),    64'(32'h22222222));
      check("t5_w2",    64'(w2_b),    64'(32'h33333333));
      check("t5_waddr", 64'(waddr_b), 64'(0));
      check("t5_wlc",   64'(wlc_b),   64'(0));
      for (int k = 0; k < 7; k++) begin
         tick();
         check("bp_valid", 64'(valid_b), 64'(1));
         check("bp_w0",    64'(w0_b),    64'(32'h11111111));
         check("bp_w1",    64'(w1_b),    64'(32'h22222222));
         check("bp_w2",    64'(w2_b),    64'(32'h33333333));
         check("bp_waddr", 64'(waddr_b), 64'(0));
         check("bp_rd_en", 64'(rd_en_b), 64'(0));
      end
      ready_b = 1'b1;
      tick();                       // window accepted, next RD0
      check("bp_rel_rd_en", 64'(rd_en_b), 64'(1));
      check("bp_rel_addr",  64'(addr_b),  64'(1));
      check("bp_rel_waddr", 64'(waddr_b), 64'(1));
      check("bp_rel_valid", 64'(valid_b), 64'(0));
      tick();
      tick();
      rstb_n = 1'b0;
      #1;
      zero_b("async_reset_b");
      rstb_n = 1'b1;
      ready_b = 1'b0;

      // ---- small geometry: reference window sequence ----
      for (int r = 1; r <= SH - 2; r++) begin
         for (int c = 0; c < SWPL; c++) begin
            exp_rd.push_back((r - 1) * SWPL + c);
            exp_rd.push_back(r * SWPL + c);
            exp_rd.push_back((r + 1) * SWPL + c);
            exp_w0.push_back(mem_s[(r - 1) * SWPL + c]);
            exp_w1.push_back(mem_s[r * SWPL + c]);
            exp_w2.push_back(mem_s[(r + 1) * SWPL + c]);
            exp_c.push_back(c);
            exp_l.push_back((r - 1) % 3);
         end
      end

      // ---- small geometry: random backpressure, start during RD2 and DONE ----
      start_s = 1'b1;
      tick();
      start_s = 1'b0;
      windows = 0; rd_idx = 0; injected = 1'b0; stalled = 1'b0; done = 1'b0;
      for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
         if (stalled) begin
            check("stall_valid", 64'(valid_s), 64'(1));
            check("stall_w0",    64'(w0_s),    64'(pw0));
            check("stall_w1",    64'(w1_s),    64'(pw1));
            check("stall_w2",    64'(w2_s),    64'(pw2));
            check("stall_waddr", 64'(waddr_s), 64'(pwa));
            check("stall_wlc",   64'(wlc_s),   64'(pwl));
         end
         if (rd_en_s) begin
            if (exp_rd.size() == 0) check("rd_extra", 64'(1), 64'(0));
            else                    check("rd_addr", 64'(addr_s), 64'(exp_rd.pop_front()));
            if ((rd_idx % 3) == 2 && !injected) begin
               start_s  = 1'b1;     // sampled at the edge ending RD2
               injected = 1'b1;
            end
            rd_idx++;
         end
         ready_s = ($urandom_range(0, 99) < 60);
         if (valid_s && ready_s) begin
            if (exp_c.size() == 0) begin
               check("win_extra", 64'(1), 64'(0));
            end else begin
               check("win_w0",    64'(w0_s),    64'(exp_w0.pop_front()));
               check("win_w1",    64'(w1_s),    64'(exp_w1.pop_front()));
               check("win_w2",    64'(w2_s),    64'(exp_w2.pop_front()));
               check("win_waddr", 64'(waddr_s), 64'(exp_c.pop_front()));
               check("win_wlc",   64'(wlc_s),   64'(exp_l.pop_front()));
            end
            windows++;
         end
         stalled = valid_s && !ready_s;
         pw0 = w0_s; pw1 = w1_s; pw2 = w2_s; pwa = waddr_s; pwl = wlc_s;
         if (eoo_s) begin
            check("eoo_busy", 64'(busy_s), 64'(0));
            done    = 1'b1;
            start_s = 1'b1;         // sampled at the edge ending DONE
         end
         tick();
         start_s = 1'b0;
      end
      check("frame_done",     64'(done),          64'(1));
      check("eoo_width",      64'(eoo_s),         64'(0));
      check("window_count",   64'(windows),       64'(8));
      check("reads_consumed", 64'(exp_rd.size()), 64'(0));
      seen = 0;
      repeat (10) begin
         tick();
         if (rd_en_s || busy_s || valid_s) seen++;
      end
      check("no_extra_frame", 64'(seen), 64'(0));

      // ---- mid-frame reset and restart ----
      ready_s = 1'b1;
      start_s = 1'b1;
      tick();
      start_s = 1'b0;
      check("restart_addr",  64'(addr_s),  64'(0));
      check("restart_rd_en", 64'(rd_en_s), 64'(1));
      tick();
      tick();
      rsts_n = 1'b0;
      #1;
      zero_s("async_reset_s");
      rsts_n = 1'b1;
      tick();
      start_s = 1'b1;
      tick();                       // first RD0 of the new frame
      start_s = 1'b0;
      check("restart2_addr",  64'(addr_s),  64'(0));
      check("restart2_rd_en", 64'(rd_en_s), 64'(1));
      cnt = 1;
      while (!eoo_s && cnt < 200) begin
         tick();
         cnt++;
      end
      // 5 cycles x 8 windows from first RD0 to last PRES, then DONE.
      check("frame_len", 64'(cnt), 64'(41));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
